// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver with a first-word fall-through RX FIFO and
//               single-cycle framing/overrun/parity error pulses.
//               Optional even-parity support when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam int c_AW = $clog2(FIFO_DEPTH);

    localparam logic [c_CW-1:0] c_CNT_MID = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_CNT_END = c_CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_PARITY    = 3'd5;
`endif

    logic              r_sync1;
    logic              r_sync2;
    logic [2:0]        r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_frame_err;
    logic              r_overrun;
    logic [7:0]        r_rx_data;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;

    logic              w_rxs;
    logic              w_cnt_end;
    logic              w_stop_sample;
    logic              w_par_ok;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_byte_ok;
    logic              w_push;
    logic              w_overrun_evt;
    logic [c_AW-1:0]   w_rd_next_idx;

    assign w_rxs         = r_sync2;
    assign w_cnt_end     = (r_cnt == c_CNT_END);
    assign w_stop_sample = (r_state == c_STOP) && w_cnt_end;

    assign w_fifo_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                           (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop         = !w_fifo_empty && rx_ready;
    assign w_rd_next_idx = r_rd_ptr[c_AW-1:0] + 1'b1;

    // A pop in the same cycle frees the slot, so a full FIFO only overruns
    // when the consumer is not draining it.
    assign w_byte_ok     = w_stop_sample && w_rxs && w_par_ok;
    assign w_push        = w_byte_ok && (!w_fifo_full || w_pop);
    assign w_overrun_evt = w_byte_ok && w_fifo_full && !w_pop;

    assign rx_data    = r_rx_data;
    assign rx_valid   = !w_fifo_empty;
    assign rx_busy    = (r_state != c_IDLE);
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign fifo_count = r_wr_ptr - r_rd_ptr;

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;

    assign w_par_ok   = ~^{r_shift, r_par_bit};
    assign parity_err = r_parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_stop_sample && w_rxs && !w_par_ok;
        end
    end
`else
    assign w_par_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= w_overrun_evt;
            case (r_state)
                c_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= c_START;
                        r_cnt   <= '0;
                    end
                end
                c_START: begin
                    if (r_cnt == c_CNT_MID) begin
                        r_cnt <= '0;
                        // Line back high at mid-start: treat as a glitch.
                        if (w_rxs) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_state   <= c_DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DATA: begin
                    if (w_cnt_end) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= c_PARITY;
`else
                            r_state <= c_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_PARITY: begin
                    if (w_cnt_end) begin
                        r_cnt     <= '0;
                        r_par_bit <= w_rxs;
                        r_state   <= c_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                c_STOP: begin
                    if (w_cnt_end) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= c_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_WAIT_HIGH: begin
                    if (w_rxs) begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= r_shift;
        end
    end

    // Registered head byte: tracks the post-edge FIFO head, holds when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data <= '0;
        end else if (w_fifo_empty) begin
            if (w_push) begin
                r_rx_data <= r_shift;
            end
        end else if (w_pop) begin
            if (fifo_count == {{c_AW{1'b0}}, 1'b1}) begin
                if (w_push) begin
                    r_rx_data <= r_shift;
                end
            end else begin
                r_rx_data <= r_mem[w_rd_next_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo at 16 clk/bit,
//               4-entry FIFO. Honours UART_RX_PARITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Edge (counted from the start-bit negedge) at which the stop bit is sampled:
    // 2 sync + 1 idle detect + CPB/2 start + (data[+parity]) * CPB + CPB stop.
    localparam int STOP_SAMPLE = 3 + CPB / 2 + NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    int   cyc       = 0;
    int   n_ferr    = 0;
    int   n_ovr     = 0;
    int   n_perr    = 0;
    int   n_busy    = 0;
    int   last_rise = -1;
    logic prev_valid = 1'b0;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Observes the DUT once per cycle on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_err === 1'b1)  n_ferr = n_ferr + 1;
        if (overrun === 1'b1)    n_ovr  = n_ovr + 1;
        if (parity_err === 1'b1) n_perr = n_perr + 1;
        if (rx_busy === 1'b1)    n_busy = n_busy + 1;
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) last_rise = cyc;
        prev_valid = rx_valid;
    end

    task automatic line_bits(input logic b, input int nbits);
        uart_rx = b;
        repeat (nbits * CPB) @(negedge clk);
    endtask

    // Leaves the line at stop_val; caller restores idle if needed.
    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_val, input int stop_bits);
        logic p;
        p = (^d) ^ par_flip;
        @(negedge clk);
        line_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) line_bits(d[i], 1);
`ifdef UART_RX_PARITY_EN
        line_bits(p, 1);
`endif
        line_bits(stop_val, stop_bits);
    endtask

    task automatic test_reset;
        rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        checks++; if ({frame_err, overrun, parity_err} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got %b expected 000", {frame_err, overrun, parity_err}); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_byte;
        int t0, f0, o0;
        f0 = n_ferr; o0 = n_ovr;
        @(negedge clk);
        #1 t0 = cyc;
        send_frame(8'h55, 1'b0, 1'b1, 1);
        uart_rx = 1'b1;
        checks++; if (last_rise - t0 !== 1 + STOP_SAMPLE) begin failures++; $display("FAIL single_latency: got %0d expected %0d", last_rise - t0, 1 + STOP_SAMPLE); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL single_data: got %h expected 55", rx_data); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid: got %b expected 0", rx_valid); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL single_pop_count: got %0d expected 0", fifo_count); end
        checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL single_hold_data: got %h expected 55", rx_data); end
        checks++; if (n_ferr - f0 + n_ovr - o0 !== 0) begin failures++; $display("FAIL single_no_err: got %0d expected 0", n_ferr - f0 + n_ovr - o0); end
    endtask

    task automatic test_glitch;
        int b0, f0;
        b0 = n_busy; f0 = n_ferr;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        // START runs CPB/2 cycles before the mid-start sample sees the line high.
        checks++; if (n_busy - b0 !== CPB / 2) begin failures++; $display("FAIL glitch_busy_cycles: got %0d expected %0d", n_busy - b0, CPB / 2); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL glitch_count: got %0d expected 0", fifo_count); end
        checks++; if (n_ferr - f0 !== 0) begin failures++; $display("FAIL glitch_ferr: got %0d expected 0", n_ferr - f0); end
    endtask

    task automatic test_frame_err;
        int f0;
        f0 = n_ferr;
        send_frame(8'hA3, 1'b0, 1'b0, 40);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL break_busy: got %b expected 1", rx_busy); end
        checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL break_ferr_pulses: got %0d expected 1", n_ferr - f0); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL break_count: got %0d expected 0", fifo_count); end
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL break_release_busy: got %b expected 0", rx_busy); end
        send_frame(8'h3C, 1'b0, 1'b1, 1);
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL after_break_data: got %h expected 3c", rx_data); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL after_break_count: got %0d expected 1", fifo_count); end
        checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL after_break_ferr: got %0d expected 1", n_ferr - f0); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_overrun;
        int o0;
        o0 = n_ovr;
        rx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1, 1);
        checks++; if (n_ovr - o0 !== 0) begin failures++; $display("FAIL fill_no_overrun: got %0d expected 0", n_ovr - o0); end
        send_frame(8'h05, 1'b0, 1'b1, 1);
        repeat (2) @(negedge clk);
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL overrun_count: got %0d expected 4", fifo_count); end
        checks++; if (n_ovr - o0 !== 1) begin failures++; $display("FAIL overrun_pulses: got %0d expected 1", n_ovr - o0); end
        for (int i = 0; i < 4; i++) begin
            rx_ready = 1'b1;
            checks++; if (rx_data !== 8'(i + 1)) begin failures++; $display("FAIL overrun_drain[%0d]: got %h expected %h", i, rx_data, 8'(i + 1)); end
            @(negedge clk);
        end
        rx_ready = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL overrun_drain_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_full_push_pop;
        int o0;
        o0 = n_ovr;
        rx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1, 1);
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL pp_fill_count: got %0d expected 4", fifo_count); end
        fork
            send_frame(8'h05, 1'b0, 1'b1, 1);
            begin
                // Start-bit negedge is the first one counted; ready covers the stop-sample edge.
                repeat (STOP_SAMPLE) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        checks++; if (n_ovr - o0 !== 0) begin failures++; $display("FAIL pp_no_overrun: got %0d expected 0", n_ovr - o0); end
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL pp_count: got %0d expected 4", fifo_count); end
        for (int i = 0; i < 4; i++) begin
            rx_ready = 1'b1;
            checks++; if (rx_data !== 8'(i + 2)) begin failures++; $display("FAIL pp_drain[%0d]: got %h expected %h", i, rx_data, 8'(i + 2)); end
            @(negedge clk);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        int p0, f0;
        p0 = n_perr; f0 = n_ferr;
        @(negedge clk);
        line_bits(1'b0, 1);
        line_bits(1'b1, 3);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b expected 1", rx_busy); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy_in_reset: got %b expected 0", rx_busy); end
        rst = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL midrst_count: got %0d expected 0", fifo_count); end
        send_frame(8'h7E, 1'b0, 1'b1, 1);
        repeat (2) @(negedge clk);
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL midrst_7e_count: got %0d expected 1", fifo_count); end
        checks++; if (rx_data !== 8'h7E) begin failures++; $display("FAIL midrst_7e_data: got %h expected 7e", rx_data); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
`ifdef UART_RX_PARITY_EN
        send_frame(8'h7E, 1'b1, 1'b1, 1);
        repeat (2) @(negedge clk);
        checks++; if (n_perr - p0 !== 1) begin failures++; $display("FAIL parity_pulses: got %0d expected 1", n_perr - p0); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL parity_count: got %0d expected 0", fifo_count); end
`else
        checks++; if (n_perr - p0 !== 0) begin failures++; $display("FAIL parity_tied_low: got %0d expected 0", n_perr - p0); end
`endif
        checks++; if (n_ferr - f0 !== 0) begin failures++; $display("FAIL midrst_ferr: got %0d expected 0", n_ferr - f0); end
    endtask

    initial begin
        rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0;
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_push_pop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
